ddr2_mem_responder: RTL and testbench
=====================================

DDR2_MEM_RESPONDER -- requirements
Module: ddr2_mem_responder

Interface
REQ-001 Parameter CL, default 4: read CAS latency in clk cycles; legal values 3..6.
REQ-002 Parameter MEM_AW, default 10: storage word-address width.
REQ-003 clk  input  1  single clock, all logic on posedge; reset asynchronous active-low rst_n.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cke, csbar, rasbar, casbar, webar  input  1 each  command pins from PHY pads.
REQ-006 ba  input  2  bank address; a  input  13  row/column address, a[10] = auto/all flag.
REQ-007 dm  input  2  write byte mask, bit i masks dq[8i+7:8i]; odt  input  1  ignored.
REQ-008 dq_in  input  16  write data; dqs_in  input  2  write strobe, sampled only for strobe_err.
REQ-009 dq_out  output  16, dqs_out  output  2, dq_oe  output  1  read data, strobe and drive enable.
REQ-010 cmd_err  output  1  one-cycle pulse on an illegal or ignored command.

Function
REQ-011 Commands decoded on every posedge when cke=1 and csbar=0, as {rasbar,casbar,webar}: 111 NOP, 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 MRS; csbar=1 is deselect (NOP).
REQ-012 Per-bank state: open flag plus 13-bit row; ACT to a closed bank opens it; ACT to an open bank pulses cmd_err and is ignored.
REQ-013 PRE closes bank ba; PRE with a[10]=1 closes all banks; PRE to a closed bank is legal and silent.
REQ-014 REF with any bank open pulses cmd_err and is ignored; otherwise REF is a no-op.
REQ-015 MRS with ba=00 loads the runtime CAS latency from a[6:4] if 3..6, else cmd_err and unchanged; MRS is legal only with all banks closed.
REQ-016 Word index = {ba, row[1:0], col[MEM_AW-5:2], beat}; col = a[9:0]; beat = (col[1:0] + n) mod 4 for beat n of a burst (BL4, sequential wrap).
REQ-017 FSM states: IDLE, RD_WAIT, RD_BURST, WR_WAIT, WR_BURST, SELF_REF.
REQ-018 READ to an open bank in IDLE -> RD_WAIT; dq_oe=1 and dqs_out=00 (preamble) at cycle CL-1 after the command cycle; beats 0..3 on dq_out at cycles CL..CL+3; dqs_out=11 on beats 0 and 2, 00 on beats 1 and 3; dq_oe drops the cycle after beat 3 -> IDLE.
REQ-019 WRITE to an open bank in IDLE -> WR_WAIT; write latency WL=CL-1; dq_in sampled at cycles WL..WL+3 (WR_BURST) and stored -> IDLE; dq_oe stays 0.
REQ-020 strobe_err: during WR_BURST, dqs_in not equal to 11,00,11,00 on beats 0..3 pulses cmd_err; the data is still written.
REQ-021 READ/WRITE to a closed bank, or any READ/WRITE/ACT/MRS arriving outside IDLE: cmd_err pulse, command ignored, burst in progress unaffected; NOP/PRE are accepted anytime (PRE closes the bank, burst completes).
REQ-022 cke=0 sampled in IDLE with all banks closed -> SELF_REF; all commands ignored; cke=1 -> IDLE after one cycle; cke=0 in any other state pulses cmd_err and is ignored.
REQ-023 Read/write latency beyond CL uses the runtime latency latched at command acceptance; an MRS cannot change an in-flight burst.

Reset
REQ-024 rst_n=0 forces immediately: FSM IDLE, all banks closed, runtime latency = CL, dq_oe=0, dq_out=0, dqs_out=00, cmd_err=0.
REQ-025 Reset mid-burst aborts the burst with no partial further writes; storage contents are not cleared.

Configuration
REQ-026 DDR2_RESP_DM_EN defined: dm[i]=1 suppresses the write of byte i; undefined: dm ignored, all 16 bits always written.

Structure
REQ-027 ddr2_pkg holds the command encoding constants, the FSM state enum, BL=4 and the legal CL range.
REQ-028 Storage in sub-module ddr2_resp_mem: 2**MEM_AW x 16, one synchronous write port with 2-bit byte enable, one asynchronous read port.

Verification
REQ-029 ACT ba=1 row=2; WRITE ba=1 col=4, data 1111,2222,3333,4444; READ col=4 -> CL=4: dq_oe at +3, data 1111..4444 on +4..+7, dqs 11,00,11,00.
REQ-030 READ col=6 after the above write -> wrap order 3333,4444,1111,2222.
REQ-031 READ to closed bank 2 -> cmd_err pulse at +1, dq_oe stays 0 throughout.
REQ-032 MRS a[6:4]=5 with banks closed, then ACT/READ -> first data beat at +5; MRS a[6:4]=7 -> cmd_err, latency unchanged.
REQ-033 rst_n low at burst beat 1 -> dq_oe=0 same cycle, FSM IDLE; following READ returns pre-reset stored data.
REQ-034 DDR2_RESP_DM_EN defined, WRITE 0xAAAA with dm=01 over stored 0x1234 -> readback 0xAA34; undefined -> 0xAAAA.

Source files
------------

// File: rtl/ddr2_pkg.sv
// Shared definitions for the DDR2 memory responder: command encodings,
// FSM state encoding, burst length and the legal CAS latency range.
package ddr2_pkg;

   // {rasbar, casbar, webar} with csbar=0 and cke=1
   localparam logic [2:0] CMD_NOP   = 3'b111;
   localparam logic [2:0] CMD_ACT   = 3'b011;
   localparam logic [2:0] CMD_READ  = 3'b101;
   localparam logic [2:0] CMD_WRITE = 3'b100;
   localparam logic [2:0] CMD_PRE   = 3'b010;
   localparam logic [2:0] CMD_REF   = 3'b001;
   localparam logic [2:0] CMD_MRS   = 3'b000;

   localparam int BL     = 4;
   localparam int CL_MIN = 3;
   localparam int CL_MAX = 6;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_WAIT  = 3'd1,
      ST_RD_BURST = 3'd2,
      ST_WR_WAIT  = 3'd3,
      ST_WR_BURST = 3'd4,
      ST_SELF_REF = 3'd5
   } state_e;

   function automatic logic cl_legal(input logic [2:0] cl);
      return (cl >= 3'(CL_MIN)) && (cl <= 3'(CL_MAX));
   endfunction

   // Data strobe toggles 11,00,11,00 across the four beats of a burst.
   function automatic logic [1:0] strobe_exp(input logic [1:0] beat);
      return beat[0] ? 2'b00 : 2'b11;
   endfunction

endpackage

// File: rtl/ddr2_mem_responder_if.sv
// DDR2 pad-level bus between a controller/PHY (master) and the memory
// responder model (slave).
interface ddr2_mem_responder_if;
   logic        cke;
   logic        csbar;
   logic        rasbar;
   logic        casbar;
   logic        webar;
   logic [1:0]  ba;
   logic [12:0] a;
   logic [1:0]  dm;
   logic        odt;
   logic [15:0] dq_in;
   logic [1:0]  dqs_in;
   logic [15:0] dq_out;
   logic [1:0]  dqs_out;
   logic        dq_oe;
   logic        cmd_err;

   modport master (
      output cke, csbar, rasbar, casbar, webar, ba, a, dm, odt, dq_in, dqs_in,
      input  dq_out, dqs_out, dq_oe, cmd_err
   );

   modport slave (
      input  cke, csbar, rasbar, casbar, webar, ba, a, dm, odt, dq_in, dqs_in,
      output dq_out, dqs_out, dq_oe, cmd_err
   );
endinterface

// File: rtl/ddr2_resp_mem.sv
// Responder storage: 2**AW x 16 words, one synchronous byte-enabled write
// port and one asynchronous read port sharing a single address.
module ddr2_resp_mem #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [1:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);

   logic [15:0] mem [2**AW];

   // NOTE: storage is deliberately not reset, so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (we) begin
         if (be[0]) mem[addr][7:0]  <= wdata[7:0];
         if (be[1]) mem[addr][15:8] <= wdata[15:8];
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ddr2_mem_responder.sv
// DDR2 memory responder: decodes pad commands, tracks open banks and serves
// BL4 read/write bursts. Define DDR2_RESP_DM_EN to honour the dm byte mask.
module ddr2_mem_responder
   import ddr2_pkg::*;
#(
   parameter int CL     = 4,
   parameter int MEM_AW = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ddr2_mem_responder_if.slave  bus
);

   localparam int CW = MEM_AW - 4;

   localparam logic [2:0] S_IDLE     = ST_IDLE;
   localparam logic [2:0] S_RD_WAIT  = ST_RD_WAIT;
   localparam logic [2:0] S_RD_BURST = ST_RD_BURST;
   localparam logic [2:0] S_WR_WAIT  = ST_WR_WAIT;
   localparam logic [2:0] S_WR_BURST = ST_WR_BURST;
   localparam logic [2:0] S_SELF_REF = ST_SELF_REF;

   logic [2:0]       state;
   logic [3:0]       bank_open;
   logic [3:0][12:0] bank_row;
   logic [2:0]       cur_cl;
   logic [2:0]       lat;
   logic [2:0]       cnt;
   logic [2:0]       beat;
   logic [1:0]       bst_ba;
   logic [1:0]       bst_row;
   logic [CW-1:0]    bst_col;

   logic [2:0]        cmd;
   logic              cmd_valid;
   logic              idle;
   logic              all_closed;
   logic              acc_act, acc_rd, acc_wr, acc_pre, acc_mrs;
   logic              err_cmd, err_cke, err_strobe;
   logic              enter_sr;
   logic              wr_beat;
   logic [1:0]        n_beat;
   logic [1:0]        word_beat;
   logic [MEM_AW-1:0] mem_addr;
   logic [15:0]       mem_rdata;
   logic [1:0]        mem_be;
   logic              unused_bits;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      cmd        = {bus.rasbar, bus.casbar, bus.webar};
      idle       = (state == S_IDLE);
      all_closed = (bank_open == 4'b0000);
      cmd_valid  = bus.cke && !bus.csbar && (state != S_SELF_REF);
      acc_act    = 1'b0;
      acc_rd     = 1'b0;
      acc_wr     = 1'b0;
      acc_pre    = 1'b0;
      acc_mrs    = 1'b0;
      err_cmd    = 1'b0;
      if (cmd_valid) begin
         case (cmd)
            CMD_ACT:   if (idle && !bank_open[bus.ba]) acc_act = 1'b1; else err_cmd = 1'b1;
            CMD_READ:  if (idle && bank_open[bus.ba])  acc_rd  = 1'b1; else err_cmd = 1'b1;
            CMD_WRITE: if (idle && bank_open[bus.ba])  acc_wr  = 1'b1; else err_cmd = 1'b1;
            CMD_PRE:   acc_pre = 1'b1;
            CMD_REF:   err_cmd = !all_closed;
            CMD_MRS: begin
               // Only mode register 0 carries the CAS latency; other banks are accepted silently.
               if (!(idle && all_closed))  err_cmd = 1'b1;
               else if (bus.ba == 2'b00) begin
                  if (cl_legal(bus.a[6:4])) acc_mrs = 1'b1;
                  else                      err_cmd = 1'b1;
               end
            end
            default: ;
         endcase
      end

      enter_sr = !bus.cke && idle && all_closed;
      err_cke  = !bus.cke && !enter_sr && (state != S_SELF_REF);

      wr_beat    = ((state == S_WR_WAIT) && (cnt == lat - 3'd1)) || (state == S_WR_BURST);
      n_beat     = ((state == S_RD_BURST) || (state == S_WR_BURST)) ? beat[1:0] : 2'b00;
      err_strobe = wr_beat && (bus.dqs_in != strobe_exp(n_beat));
      word_beat  = bst_col[1:0] + n_beat;
      mem_addr   = {bst_ba, bst_row, bst_col[CW-1:2], word_beat};
   end

`ifdef DDR2_RESP_DM_EN
   assign mem_be      = ~bus.dm;
   assign unused_bits = ^{bus.odt, bank_row[0][12:2], bank_row[1][12:2],
                          bank_row[2][12:2], bank_row[3][12:2]};
`else
   assign mem_be      = 2'b11;
   assign unused_bits = ^{bus.odt, bus.dm, bank_row[0][12:2], bank_row[1][12:2],
                          bank_row[2][12:2], bank_row[3][12:2]};
`endif

   ddr2_resp_mem #(.AW(MEM_AW)) u_mem (
      .clk   (clk),
      .we    (wr_beat),
      .be    (mem_be),
      .addr  (mem_addr),
      .wdata (bus.dq_in),
      .rdata (mem_rdata)
   );

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         bank_open   <= '0;
         bank_row    <= '0;
         cur_cl      <= 3'(CL);
         lat         <= 3'(CL);
         cnt         <= '0;
         beat        <= '0;
         bst_ba      <= '0;
         bst_row     <= '0;
         bst_col     <= '0;
         bus.dq_out  <= '0;
         bus.dqs_out <= '0;
         bus.dq_oe   <= 1'b0;
         bus.cmd_err <= 1'b0;
      end else begin
         bus.cmd_err <= err_cmd | err_cke | err_strobe;

         if (acc_act) begin
            bank_open[bus.ba] <= 1'b1;
            bank_row[bus.ba]  <= bus.a;
         end
         if (acc_pre) begin
            if (bus.a[10]) bank_open         <= '0;
            else           bank_open[bus.ba] <= 1'b0;
         end
         if (acc_mrs) cur_cl <= bus.a[6:4];

         case (state)
            S_IDLE: begin
               if (enter_sr) begin
                  state <= S_SELF_REF;
               end else if (acc_rd || acc_wr) begin
                  // Latency and address are frozen here so later MRS/PRE cannot disturb the burst.
                  state   <= acc_rd ? S_RD_WAIT : S_WR_WAIT;
                  lat     <= cur_cl;
                  cnt     <= 3'd1;
                  bst_ba  <= bus.ba;
                  bst_row <= bank_row[bus.ba][1:0];
                  bst_col <= bus.a[CW-1:0];
               end
            end
            S_RD_WAIT: begin
               cnt <= cnt + 3'd1;
               if (cnt == lat - 3'd2) begin
                  bus.dq_oe   <= 1'b1;
                  bus.dqs_out <= 2'b00;
               end
               if (cnt == lat - 3'd1) begin
                  bus.dq_out  <= mem_rdata;
                  bus.dqs_out <= strobe_exp(2'd0);
                  beat        <= 3'd1;
                  state       <= S_RD_BURST;
               end
            end
            S_RD_BURST: begin
               if (beat == 3'(BL)) begin
                  bus.dq_oe   <= 1'b0;
                  bus.dq_out  <= '0;
                  bus.dqs_out <= 2'b00;
                  state       <= S_IDLE;
               end else begin
                  bus.dq_out  <= mem_rdata;
                  bus.dqs_out <= strobe_exp(beat[1:0]);
                  beat        <= beat + 3'd1;
               end
            end
            S_WR_WAIT: begin
               cnt <= cnt + 3'd1;
               if (cnt == lat - 3'd1) begin
                  beat  <= 3'd1;
                  state <= S_WR_BURST;
               end
            end
            S_WR_BURST: begin
               if (beat == 3'(BL - 1)) state <= S_IDLE;
               else                    beat  <= beat + 3'd1;
            end
            S_SELF_REF: begin
               if (bus.cke) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr2_mem_responder.sv
// Directed self-checking bench for ddr2_mem_responder (CL=4, MEM_AW=10);
// expectations follow DDR2_RESP_DM_EN when it is defined for the build.
module tb_ddr2_mem_responder;

   localparam logic [2:0] C_NOP   = 3'b111;
   localparam logic [2:0] C_ACT   = 3'b011;
   localparam logic [2:0] C_READ  = 3'b101;
   localparam logic [2:0] C_WRITE = 3'b100;
   localparam logic [2:0] C_PRE   = 3'b010;
   localparam logic [2:0] C_MRS   = 3'b000;

`ifdef DDR2_RESP_DM_EN
   localparam logic [15:0] EXP_DM = 16'hAA34;
`else
   localparam logic [15:0] EXP_DM = 16'hAAAA;
`endif

   localparam logic [3:0][1:0] STB_OK  = {2'b00, 2'b11, 2'b00, 2'b11};
   localparam logic [3:0][1:0] STB_BAD = {2'b00, 2'b11, 2'b11, 2'b11};

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   ddr2_mem_responder_if bus ();

   ddr2_mem_responder #(.CL(4), .MEM_AW(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one command for one sampling edge; returns 1ns after that edge (offset +1).
   task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr);
      {bus.rasbar, bus.casbar, bus.webar} = c;
      bus.ba = b;
      bus.a  = addr;
      tick(1);
      {bus.rasbar, bus.casbar, bus.webar} = C_NOP;
      bus.ba = 2'b00;
      bus.a  = '0;
   endtask

   task automatic do_write(input logic [1:0] b, input logic [9:0] col, input int lat,
                           input logic [3:0][15:0] d, input logic [3:0][1:0] s,
                           input logic [1:0] m, input string tag);
      logic [1:0] nominal;
      issue(C_WRITE, b, {3'b000, col});
      check({tag, ".acc"}, 16'(bus.cmd_err), 16'd0);
      tick(lat - 2);
      for (int n = 0; n < 4; n++) begin
         nominal    = (n % 2 == 0) ? 2'b11 : 2'b00;
         bus.dq_in  = d[n];
         bus.dqs_in = s[n];
         bus.dm     = m;
         tick(1);
         check($sformatf("%s.err%0d", tag, n), 16'(bus.cmd_err), 16'(s[n] !== nominal));
         check($sformatf("%s.oe%0d", tag, n), 16'(bus.dq_oe), 16'd0);
      end
      bus.dq_in  = '0;
      bus.dqs_in = 2'b00;
      bus.dm     = 2'b00;
   endtask

   task automatic do_read(input logic [1:0] b, input logic [9:0] col, input int lat,
                          input logic [3:0][15:0] e, input string tag);
      issue(C_READ, b, {3'b000, col});
      check({tag, ".acc"}, 16'(bus.cmd_err), 16'd0);
      tick(lat - 3);
      check({tag, ".oe_early"}, 16'(bus.dq_oe), 16'd0);
      tick(1);
      check({tag, ".pre_oe"}, 16'(bus.dq_oe), 16'd1);
      check({tag, ".pre_dqs"}, 16'(bus.dqs_out), 16'd0);
      for (int n = 0; n < 4; n++) begin
         tick(1);
         check($sformatf("%s.d%0d", tag, n), bus.dq_out, e[n]);
         check($sformatf("%s.s%0d", tag, n), 16'(bus.dqs_out), (n % 2 == 0) ? 16'd3 : 16'd0);
      end
      tick(1);
      check({tag, ".oe_off"}, 16'(bus.dq_oe), 16'd0);
   endtask

   initial begin
      logic oe_seen;

      rst_n      = 1'b0;
      bus.cke    = 1'b1;
      bus.csbar  = 1'b0;
      {bus.rasbar, bus.casbar, bus.webar} = C_NOP;
      bus.ba     = 2'b00;
      bus.a      = '0;
      bus.dm     = 2'b00;
      bus.odt    = 1'b0;
      bus.dq_in  = '0;
      bus.dqs_in = 2'b00;

      tick(1);
      check("rst.oe", 16'(bus.dq_oe), 16'd0);
      check("rst.dq", bus.dq_out, 16'd0);
      check("rst.dqs", 16'(bus.dqs_out), 16'd0);
      check("rst.err", 16'(bus.cmd_err), 16'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Basic write then aligned and wrapped reads, bank 1 row 2.
      issue(C_ACT, 2'd1, 13'd2);
      check("act1", 16'(bus.cmd_err), 16'd0);
      do_write(2'd1, 10'd4, 4, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, STB_OK, 2'b00, "wr1");
      do_read(2'd1, 10'd4, 4, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, "rd_c4");
      do_read(2'd1, 10'd6, 4, {16'h2222, 16'h1111, 16'h4444, 16'h3333}, "rd_c6");

      // Read to a closed bank: one-cycle error pulse, no drive.
      issue(C_READ, 2'd2, 13'd0);
      check("rd_closed.err", 16'(bus.cmd_err), 16'd1);
      oe_seen = bus.dq_oe;
      tick(1);
      check("rd_closed.pulse", 16'(bus.cmd_err), 16'd0);
      repeat (7) begin
         oe_seen |= bus.dq_oe;
         tick(1);
      end
      check("rd_closed.oe", 16'(oe_seen), 16'd0);

      issue(C_ACT, 2'd1, 13'd5);
      check("act_open.err", 16'(bus.cmd_err), 16'd1);

      // Bad strobe on beat 1 flags an error but the data still lands.
      do_write(2'd1, 10'd8, 4, {16'h8888, 16'h7777, 16'h6666, 16'h5555}, STB_BAD, 2'b00, "wr_stb");
      do_read(2'd1, 10'd8, 4, {16'h8888, 16'h7777, 16'h6666, 16'h5555}, "rd_stb");

      bus.cke = 1'b0;
      tick(1);
      check("cke_open.err", 16'(bus.cmd_err), 16'd1);
      bus.cke = 1'b1;
      tick(1);

      issue(C_PRE, 2'd0, 13'h400);
      check("pre_all", 16'(bus.cmd_err), 16'd0);

      // Self refresh: entry is silent and an ACT while in it is ignored.
      bus.cke = 1'b0;
      tick(1);
      check("sr.enter", 16'(bus.cmd_err), 16'd0);
      issue(C_ACT, 2'd3, 13'd1);
      check("sr.act_ign", 16'(bus.cmd_err), 16'd0);
      bus.cke = 1'b1;
      tick(1);
      issue(C_ACT, 2'd3, 13'd1);
      check("sr.exit_act", 16'(bus.cmd_err), 16'd0);
      issue(C_PRE, 2'd0, 13'h400);

      // Runtime latency 5, then an illegal MRS leaves it at 5.
      issue(C_MRS, 2'd0, 13'h050);
      check("mrs5", 16'(bus.cmd_err), 16'd0);
      issue(C_ACT, 2'd1, 13'd2);
      do_read(2'd1, 10'd4, 5, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, "rd_cl5");
      issue(C_PRE, 2'd0, 13'h400);
      issue(C_MRS, 2'd0, 13'h070);
      check("mrs7.err", 16'(bus.cmd_err), 16'd1);
      issue(C_ACT, 2'd1, 13'd2);
      check("act_after_mrs7", 16'(bus.cmd_err), 16'd0);
      do_read(2'd1, 10'd4, 5, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, "rd_cl5b");

      // Byte mask: low byte masked on the second write.
      do_write(2'd1, 10'd12, 5, {4{16'h1234}}, STB_OK, 2'b00, "wr_base");
      do_write(2'd1, 10'd12, 5, {4{16'hAAAA}}, STB_OK, 2'b01, "wr_dm");
      do_read(2'd1, 10'd12, 5, {4{EXP_DM}}, "rd_dm");

      // Reset during read beat 1.
      issue(C_READ, 2'd1, 13'd4);
      tick(5);
      check("rst_mid.beat1", bus.dq_out, 16'h2222);
      rst_n = 1'b0;
      #1;
      check("rst_mid.oe", 16'(bus.dq_oe), 16'd0);
      check("rst_mid.dq", bus.dq_out, 16'd0);
      check("rst_mid.dqs", 16'(bus.dqs_out), 16'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      issue(C_ACT, 2'd1, 13'd2);
      check("post_rst.act", 16'(bus.cmd_err), 16'd0);
      do_read(2'd1, 10'd4, 4, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, "post_rst.rd");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
